// File: rtl/fetch_stage.sv
// PC/fetch stage: drives the imem address, captures the returned word into a one-entry IR for decode.
// Sequential fetch sustains one word per cycle; a branch delivers its target word two edges later; ir_ready low stalls the PC and IR.
module fetch_stage #(
    parameter int                    PC_WIDTH    = 8,
    parameter int                    INS_WIDTH   = 8,
    parameter int                    MEM_DEPTH   = 12,
    parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0,
    parameter logic [INS_WIDTH-1:0]  HALT_OPCODE = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [PC_WIDTH-1:0]   pc_out,
    input  logic [INS_WIDTH-1:0]  inscode_in,
    input  logic                  branch_en,
    input  logic [PC_WIDTH-1:0]   branch_target,
    input  logic                  resume,
    output logic [INS_WIDTH-1:0]  ir_out,
    output logic [PC_WIDTH-1:0]   ir_pc,
    output logic                  ir_valid,
    input  logic                  ir_ready,
    output logic                  halted,
    output logic                  addr_err
);

    localparam logic [PC_WIDTH-1:0] LAST_PC = PC_WIDTH'(MEM_DEPTH - 1);

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t                 state, state_nxt;
    logic [PC_WIDTH-1:0]    pc, pc_nxt;
    logic [INS_WIDTH-1:0]   ir_nxt;
    logic [PC_WIDTH-1:0]    ir_pc_nxt;
    logic                   ir_valid_nxt;
    logic                   addr_err_nxt;
    logic                   load;

    assign pc_out = pc;
    assign halted = (state == HALTED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            ir_out   <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            ir_out   <= ir_nxt;
            ir_pc    <= ir_pc_nxt;
            ir_valid <= ir_valid_nxt;
            addr_err <= addr_err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        ir_nxt       = ir_out;
        ir_pc_nxt    = ir_pc;
        ir_valid_nxt = ir_valid;
        addr_err_nxt = addr_err;
        // A full IR that drains this cycle can be refilled in the same cycle.
        load         = !ir_valid || ir_ready;

        if (branch_en) begin
            // Redirect wins over everything; the word on inscode_in is dropped.
            ir_valid_nxt = 1'b0;
            state_nxt    = FETCH;
            if (branch_target <= LAST_PC) begin
                pc_nxt = branch_target;
            end else begin
                pc_nxt       = RESET_PC;
                addr_err_nxt = 1'b1;
            end
        end else if (state == FETCH) begin
            if (load) begin
                ir_nxt       = inscode_in;
                ir_pc_nxt    = pc;
                ir_valid_nxt = 1'b1;
                pc_nxt       = (pc == LAST_PC) ? '0 : pc + PC_WIDTH'(1);
                if (inscode_in == HALT_OPCODE) begin
                    state_nxt = HALTED;
                end
            end
        end else begin
            if (ir_ready) begin
                ir_valid_nxt = 1'b0;
            end
            if (resume) begin
                state_nxt = FETCH;
            end
        end
    end

endmodule
